// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder that reuses one 4-bit slice, processing one nibble per clock, LSB first.
// Operands and results move through valid/ready handshakes. Every output comes from a register or is decoded from state.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          cout_reg;
  logic          ovf_reg;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = ovf_reg;

  // The shared 4-bit slice: select the nibble pair chosen by the counter and add it with the chained carry.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            sum_reg <= '0;
            cnt     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
              sum_reg[4*i +: 4] <= slice[3:0];
            end
          end
          carry <= slice[4];
          // The last slice holds the sign bits, so this is where the signed overflow becomes known.
          if (cnt == LAST) begin
            cout_reg <= slice[4];
            ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (slice[3] != a_reg[W-1]);
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4). It runs directed cases, backpressure, a mid-add reset and random operands.
// Expected results come from a plain full-width arithmetic model.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks;
  int failures;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word add, with signed overflow taken from the operand and result sign bits.
  function automatic logic [W+1:0] refAdd(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                          input logic op_cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
    ovf  = (op_a[W-1] == op_b[W-1]) && (full[W-1] != op_a[W-1]);
    return {ovf, full};
  endfunction

  // Present operands for one edge, then count the edges until out_valid appears.
  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin);
    int cycles;
    a = op_a;
    b = op_b;
    cin = op_cin;
    in_valid = 1'b1;
    checkValue("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      checkValue("in_ready_busy", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      cycles++;
    end
    checkValue("latency", cycles, NIBBLES);
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                             input logic op_cin);
    logic [W+1:0] exp;
    exp = refAdd(op_a, op_b, op_cin);
    checkValue({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    checkValue({tag, "_sum"}, {16'b0, sum}, {16'b0, exp[W-1:0]});
    checkValue({tag, "_cout"}, {31'b0, cout}, {31'b0, exp[W]});
    checkValue({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp[W+1]});
    checkValue({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic drainResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkValue("drain_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("drain_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #1;
    checkValue("reset_sum", {16'b0, sum}, 32'd0);
    checkValue("reset_cout", {31'b0, cout}, 32'd0);
    checkValue("reset_overflow", {31'b0, overflow}, 32'd0);
    checkValue("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkOutput("basic", 16'h1234, 16'h4321, 1'b0);
    checkValue("basic_const", {16'b0, sum}, 32'h5555);
    drainResult();

    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("ripple", 16'hFFFF, 16'h0001, 1'b0);
    drainResult();

    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    checkValue("pos_ovf_const", {31'b0, overflow}, 32'd1);
    drainResult();

    applyStimulus(16'h8000, 16'h8000, 1'b0);
    checkOutput("neg_ovf", 16'h8000, 16'h8000, 1'b0);
    drainResult();

    applyStimulus(16'h000F, 16'h0000, 1'b1);
    checkOutput("cin", 16'h000F, 16'h0000, 1'b1);
    checkValue("cin_const", {16'b0, sum}, 32'h0010);
    drainResult();

    // Hold the result under backpressure while new operands sit waiting.
    applyStimulus(16'hABCD, 16'h1111, 1'b1);
    held_sum = sum;
    held_cout = cout;
    held_ovf = overflow;
    a = 16'h0F0F;
    b = 16'h2222;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkValue("bp_sum", {16'b0, sum}, {16'b0, held_sum});
      checkValue("bp_cout", {31'b0, cout}, {31'b0, held_cout});
      checkValue("bp_overflow", {31'b0, overflow}, {31'b0, held_ovf});
      checkValue("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkValue("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    checkOutput("bp_hold", 16'hABCD, 16'h1111, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkValue("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("bp_release_sum_kept", {16'b0, sum}, {16'b0, held_sum});
    applyStimulus(16'h0F0F, 16'h2222, 1'b0);
    checkOutput("bp_next", 16'h0F0F, 16'h2222, 1'b0);
    drainResult();

    // Abort an add after two slices with an asynchronous reset.
    a = 16'h9999;
    b = 16'h9999;
    cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkValue("abort_sum", {16'b0, sum}, 32'd0);
    checkValue("abort_cout", {31'b0, cout}, 32'd0);
    checkValue("abort_overflow", {31'b0, overflow}, 32'd0);
    checkValue("abort_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("abort_in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(16'h0101, 16'h1010, 1'b0);
    checkOutput("after_abort", 16'h0101, 16'h1010, 1'b0);
    checkValue("after_abort_const", {16'b0, sum}, 32'h1111);
    drainResult();

    for (int n = 0; n < 12; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc);
      checkOutput("random", ra, rb, rc);
      drainResult();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
